// File: rtl/fu_mul_seq.sv
// Radix-4 Booth MULT/MULTU sequencer. It runs 17 iterations through one
// shared external 34-bit adder and returns the 64-bit product on hi/lo.
module fu_mul_seq #(
   parameter int unsigned ITER  = 17,
   parameter int unsigned CNT_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        kill,
   output logic [33:0] add_din1,
   output logic [33:0] add_din2,
   output logic        add_cin,
   input  logic [33:0] add_dout,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   state_t           r_state;
   logic [33:0]      r_m;
   logic [33:0]      r_p;
   logic [33:0]      r_q;
   logic             r_qm1;
   logic [CNT_W-1:0] r_cnt;

   logic [2:0]  w_digit;
   logic [33:0] w_m2;
   logic [33:0] w_ext_a;
   logic [33:0] w_ext_b;

   assign w_digit = {r_q[1:0], r_qm1};
   assign w_m2    = {r_m[32:0], 1'b0};
   assign w_ext_a = {{2{is_signed & op_a[31]}}, op_a};
   assign w_ext_b = {{2{is_signed & op_b[31]}}, op_b};

   // Booth digit selects the partial-product multiple; subtraction is ~x + 1.
   always_comb begin
      add_din1 = '0;
      add_din2 = '0;
      add_cin  = 1'b0;
      if (r_state == S_CALC) begin
         add_din1 = r_p;
         unique case (w_digit)
            3'b001, 3'b010: add_din2 = r_m;
            3'b011:         add_din2 = w_m2;
            3'b100: begin
               add_din2 = ~w_m2;
               add_cin  = 1'b1;
            end
            3'b101, 3'b110: begin
               add_din2 = ~r_m;
               add_cin  = 1'b1;
            end
            default:        add_din2 = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_p     <= '0;
         r_q     <= '0;
         r_qm1   <= 1'b0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start && !kill) begin
                  r_m     <= w_ext_a;
                  r_q     <= w_ext_b;
                  r_qm1   <= 1'b0;
                  r_p     <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (kill) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  // {P,Q} arithmetic-shifts right by two with the new sum on top.
                  r_p   <= {add_dout[33], add_dout[33], add_dout[33:2]};
                  r_q   <= {add_dout[1:0], r_q[33:2]};
                  r_qm1 <= r_q[1];
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_CNT) begin
                     // Low 64 bits of the shifted {P,Q} are {S[31:0], Q[33:2]}.
                     hi      <= add_dout[31:0];
                     lo      <= r_q[33:2];
                     done    <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fu_mul_seq.sv
// Bench for fu_mul_seq: models the shared adder, replays directed scenarios,
// then checks random MULT/MULTU products against plain 64-bit arithmetic.
module tb_fu_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        kill;
   logic [33:0] add_din1;
   logic [33:0] add_din2;
   logic        add_cin;
   logic [33:0] add_dout;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_vec;
   int          n_err;
   logic [63:0] exp_hl;

   fu_mul_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .is_signed(is_signed),
      .op_a     (op_a),
      .op_b     (op_b),
      .kill     (kill),
      .add_din1 (add_din1),
      .add_din2 (add_din2),
      .add_cin  (add_cin),
      .add_dout (add_dout),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   // External 34-bit adder: a plain modular sum.
   assign add_dout = add_din1 + add_din2 + 34'(add_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return 64'(a) * 64'(b);
   endfunction

   // One operation with optional spurious start, kill or reset at a given cycle
   // (cycle 0 is the cycle in which start is presented).
   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input int kill_cyc,
                         input int spur_cyc, input int rst_cyc);
      is_signed = sgn;
      op_a      = a;
      op_b      = b;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         check("busy", 64'(busy), 64'd1);
         check("done", 64'(done), 64'(c == 18));
         if (c == 1) check("din1_clr", 64'(add_din1), 64'd0);
         if (c == 18) begin
            check("product", {hi, lo}, prod);
            exp_hl = prod;
         end else if (c == 1 || c == 9 || c == 17) begin
            check("hilo_hold", {hi, lo}, exp_hl);
         end
         if (c == rst_cyc) begin
            #2 rst_n = 1'b0;
            #1;
            exp_hl = '0;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_hilo", {hi, lo}, exp_hl);
            #2 rst_n = 1'b1;
            tick();
            check("rst_idle", 64'(busy), 64'd0);
            return;
         end
         if (c == kill_cyc) begin
            kill = 1'b1;
            tick();
            kill = 1'b0;
            check("kill_busy", 64'(busy), 64'd0);
            check("kill_done", 64'(done), 64'd0);
            check("kill_hilo", {hi, lo}, exp_hl);
            tick();
            check("kill_nodone", 64'(done), 64'd0);
            return;
         end
         if (c == spur_cyc) begin
            op_a      = 32'd7;
            op_b      = 32'd7;
            start     = 1'b1;
            tick();
            start     = 1'b0;
            op_a      = a;
            op_b      = b;
         end else begin
            tick();
         end
      end
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_din2", {29'd0, add_cin, add_din2}, 64'd0);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      exp_hl    = '0;
      rst_n     = 1'b0;
      start     = 1'b0;
      kill      = 1'b0;
      is_signed = 1'b0;
      op_a      = '0;
      op_b      = '0;
      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_din1", 64'(add_din1), 64'd0);
      rst_n = 1'b1;
      tick();

      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, -1, -1);
      run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9, -1, -1, -1);
      run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0007, 64'h0000_0006_FFFF_FFF9, -1, -1, -1);
      run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1, -1, -1);
      run_op(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, -1, -1, -1);

      // Start while busy is ignored; back-to-back start right after done is taken.
      run_op(1'b0, 32'd3, 32'd5, 64'd15, -1, 5, -1);
      run_op(1'b0, 32'd7, 32'd7, 64'd49, -1, -1, -1);
      run_op(1'b0, 32'd3, 32'd5, 64'd15, -1, -1, -1);
      run_op(1'b0, 32'd2, 32'd2, 64'd4, 9, -1, -1);

      // Kill on the final iteration cycle beats completion.
      run_op(1'b1, 32'd100, 32'd100, 64'd10000, 17, -1, -1);

      // kill alongside start in IDLE suppresses the start.
      start = 1'b1;
      kill  = 1'b1;
      tick();
      start = 1'b0;
      kill  = 1'b0;
      check("idle_kill_start", 64'(busy), 64'd0);
      tick();
      check("idle_kill_hilo", {hi, lo}, exp_hl);

      run_op(1'b0, 32'd9, 32'd9, 64'd81, -1, -1, 10);
      run_op(1'b0, 32'd0, 32'h0000_1234, 64'd0, -1, -1, -1);

      for (int i = 0; i < 40; i++) begin
         logic        s;
         logic [31:0] a;
         logic [31:0] b;
         s = 1'($urandom_range(1, 0));
         a = $urandom;
         b = $urandom;
         if (i % 8 == 0) a = {a[31], 31'(0)} | 32'($urandom_range(3, 0));
         run_op(s, a, b, ref_mul(s, a, b), -1, -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fu_mul_seq.md
Name: fu_mul_seq

Overview:
- Multi-cycle MULT/MULTU sequencer for the MIPS execute stage.
- Implements radix-4 Booth multiplication by time-sharing one external 34-bit carry-select adder (fu_csa34) over 17 iterations.
- Drives the adder operands and carry-in, captures its sum, and accumulates the 64-bit product into HI/LO.
- The pipeline stalls on busy and reads hi/lo after done.

Parameters:
- ITER, 17, number of Booth iterations; 34-bit extended multiplier / 2.
- CNT_W, 5, width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- op_a  input  32  multiplicand (rs); sampled with start.
- op_b  input  32  multiplier (rt); sampled with start.
- kill  input  1  pipeline flush; aborts the operation.
- add_din1  output  34  adder operand 1 (accumulator high part).
- add_din2  output  34  adder operand 2 (selected Booth multiple, possibly inverted).
- add_cin  output  1  adder carry-in; 1 for subtract.
- add_dout  input  34  adder sum, combinational from add_din1/add_din2/add_cin.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse when hi/lo are valid.
- hi  output  32  product[63:32].
- lo  output  32  product[31:0].

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE.
  - busy=0, done=0, hi=0, lo=0, counter=0, internal accumulator and multiplier registers = 0.
  - add_din1, add_din2 and add_cin are 0 in IDLE.
- Operand extension (at start):
  - M = 34-bit multiplicand: op_a sign-extended if is_signed, else zero-extended.
  - Q = 34-bit multiplier, extended the same way, plus an appended guard bit q[-1]=0.
- IDLE -> CALC on start=1:
  - Latch M and Q; clear accumulator P[33:0]; counter=0.
  - start is ignored while busy=1.
- CALC, one iteration per cycle, using digit d = {Q[1],Q[0],q[-1]}:
  - 000 and 111: din2 = 0, cin = 0.
  - 001 and 010: din2 = M, cin = 0.
  - 011: din2 = M<<1, cin = 0.
  - 100: din2 = ~(M<<1), cin = 1.
  - 101 and 110: din2 = ~M, cin = 1.
  - add_din1 = P throughout CALC.
  - S = add_dout. The 68-bit register {P,Q} loads {S[33],S[33],S,Q[33:2]}; q[-1] loads Q[1]. This is an arithmetic shift right by 2.
  - counter increments. After the iteration with counter = ITER-1, go to DONE.
- Width rule:
  - M<<1 is truncated to 34 bits, which is lossless because |M| < 2^32.
  - Two sign-copy bits keep P exact; no overflow detection is required.
  - The adder's carry_out/overflow are not used.
- DONE (1 cycle):
  - hi/lo load the low 64 bits of {P,Q}.
  - done=1 for exactly this cycle; then go to IDLE with busy=0.
  - hi/lo hold their value until the next completed operation.
- Latency: start in cycle 0 -> done in cycle 18 (17 CALC + 1 DONE). back-to-back start is accepted the cycle after done.
- kill:
  - In CALC or DONE, kill=1 forces IDLE on the next edge. done is not asserted and hi/lo are unchanged.
  - If kill and the final iteration coincide, kill wins.
  - In IDLE, kill has no effect; kill together with start in IDLE: start is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs cleared, regardless of state.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 18; hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1-18.
- MULT 0xFFFFFFFF (-1) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9. Same operands as MULTU -> hi=0x00000006, lo=0xFFFFFFF9.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000 x 0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
- Start 3 x 5. Pulse start again at cycle 5 with 7 x 7 -> ignored; result hi=0, lo=15. A new start the cycle after done -> accepted, lo=49 after 18 cycles.
- Start 3 x 5 with prior hi/lo=0/15. Then start 2 x 2 and assert kill at cycle 9 -> IDLE next cycle; no done; hi/lo still 0/15.
- Pull rst_n low at cycle 10 of an operation -> busy=0, done=0, hi=lo=0 immediately, without a clock edge. Release and run 0 x 0x1234 -> hi=lo=0.
